fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and requests instructions from a wait-state instruction memory over a req/ready handshake.
- Latches each returned word into an instruction register and presents instr/opcode to the decoder and datapath.
- Computes the next PC from the Branch/Jump decisions fed back from the decoder and ALU.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage that sits directly in front of the main control
// decoder. It holds the PC and fetches one word at a time from a wait-state
// instruction memory. Each returned word is latched into the instruction
// register and shown to the decoder. The next PC comes from the Branch and
// Jump decisions fed back from the decoder and the ALU.
//
// Two-state FSM:
//   FETCH : request in flight, instr_valid=0
//   EXEC  : instr is presented for exactly as long as the core holds it
//
// Memory handshake: imem_req is held high with a stable imem_addr until the
// memory answers with imem_ready=1. That cycle transfers imem_rdata. An
// imem_ready seen while imem_req=0 carries no meaning and is ignored.
//
// Downstream logic must qualify RegWrite and MemWrite with instr_valid.
// Opcode 0 (the reset and timeout NOP) decodes as R-type.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a fetch
// that waits TIMEOUT_CYCLES cycles is abandoned. A NOP is issued and the
// sticky fetch_err flag is set. When it is undefined, fetch_err is tied to 0.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   imem_req/addr     fetch request and byte address (addr == pc)
//   imem_ready/rdata  memory response, accepted only while imem_req=1
//   branch_taken      Branch & ALU zero
//   branch_offset     sign-extended imm16 (word offset)
//   jump, jump_index  Jump decision and instr[25:0]
//   stall             hold the current instruction in EXEC
//   pc, pc_plus4      current instruction address and its successor
//   instr, opcode     instruction register and its [31:26] field
//   instr_valid       instr may be executed this cycle (FSM is in EXEC)
//   fetch_err         sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic        run;        // low from reset until the first clock edge after it
  logic [29:0] pc_word;    // pc[1:0] is always 00, so only the word index is stored
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic [31:0] instr_d;
  logic        pc_load;
  logic        instr_load;
  logic        timeout_hit;

  // Outputs derived from state.
  assign pc          = {pc_word, 2'b00};
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = run && (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];

  // Next-PC selection: jump > branch > sequential. All adds wrap at 2^32.
  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
    end else begin
      next_pc = pc_plus4;
    end
  end

  // FSM next state and register-load controls.
  // The branch and jump decisions take effect only through pc_load.
  // pc_load is asserted only in EXEC with stall=0.
  always_comb begin
    state_nx   = state;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    instr_d    = imem_rdata;
    case (state)
      S_FETCH: begin
        if (imem_req && imem_ready) begin
          instr_load = 1'b1;
          state_nx   = S_EXEC;
        end else if (timeout_hit) begin
          instr_load = 1'b1;
          instr_d    = 32'h0000_0000;
          state_nx   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_load  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      pc_word <= RESET_PC[31:2];
      instr_q <= 32'h0000_0000;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      if (pc_load) begin
        pc_word <= next_pc[31:2];
      end
      if (instr_load) begin
        instr_q <= instr_d;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;
  logic          fetch_err_q;

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive unanswered
  // request cycle. At that edge the counter reaches TIMEOUT_CYCLES.
  assign timeout_hit = imem_req && !imem_ready && (wait_cnt == LAST);
  assign fetch_err   = fetch_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (pc_load) begin
        wait_cnt <= '0;                    // entering FETCH
      end else if (imem_req && !imem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (timeout_hit) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{branch_offset[31:30], next_pc[1:0]};
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{branch_offset[31:30], next_pc[1:0], (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// A table of instruction steps drives the fetch stage. Each step gives the
// memory wait count, the returned word, the address the fetch must appear
// at, the stall cycles, and the branch and jump inputs. Returned words are
// pushed into exp_q when the memory answers. They are popped and compared
// when instr_valid shows the instruction. Hand-written sequences cover the
// following cases:
//   - stall followed by a reset during a fetch wait
//   - fetch timeout (or the unbounded wait when the timeout is disabled)
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic [31:0] addr;
    int          stalls;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
  } vec_t;

  vec_t vt[13];

  fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .stall        (stall),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .fetch_err    (fetch_err)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
    stall         = 1'b0;
  endtask

  // Driver: serve one fetch after `waits` wait cycles. The first call point
  // is one cycle into FETCH. Branch, jump and stall are randomised
  // throughout, because none of them may affect a fetch.
  task automatic do_fetch(input string tag, input int waits, input logic [31:0] rdata,
                          input logic [31:0] addr);
    logic [31:0] exp_w;
    for (int c = 0; c <= waits; c++) begin
      chk($sformatf("%s_req_c%0d", tag, c), 32'(imem_req), 32'd1);
      chk($sformatf("%s_addr_c%0d", tag, c), imem_addr, addr);
      chk($sformatf("%s_valid_c%0d", tag, c), 32'(instr_valid), 32'd0);
      branch_taken  = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      stall         = 1'($urandom_range(0, 1));
      branch_offset = $urandom;
      jump_index    = 26'($urandom);
      imem_ready    = (c == waits);
      imem_rdata    = (c == waits) ? rdata : $urandom;
      if (c == waits) exp_q.push_back(rdata);
      step();
    end
    clear_inputs();
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_req_off"}, 32'(imem_req), 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb actual=empty required=entry", tag);
    end else begin
      exp_w = exp_q.pop_front();
      chk({tag, "_instr"}, instr, exp_w);
      chk({tag, "_opcode"}, 32'(opcode), 32'(exp_w[31:26]));
    end
  endtask

  // Driver: hold EXEC for `stalls` cycles, then release it with the given
  // branch and jump decision. While stall=1, the decisions are random, and
  // memory ready pulses while imem_req=0. All of these must be ignored.
  task automatic do_exec(input string tag, input int stalls, input logic [31:0] cur_pc,
                         input logic br, input logic [31:0] off, input logic jmp,
                         input logic [25:0] idx);
    logic [31:0] held;
    held = instr;
    for (int s = 0; s < stalls; s++) begin
      stall         = 1'b1;
      branch_taken  = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      branch_offset = $urandom;
      jump_index    = 26'($urandom);
      imem_ready    = 1'b1;
      imem_rdata    = $urandom;
      step();
      chk($sformatf("%s_stall_valid_s%0d", tag, s), 32'(instr_valid), 32'd1);
      chk($sformatf("%s_stall_pc_s%0d", tag, s), pc, cur_pc);
      chk($sformatf("%s_stall_instr_s%0d", tag, s), instr, held);
    end
    clear_inputs();
    branch_taken  = br;
    branch_offset = off;
    jump          = jmp;
    jump_index    = idx;
    chk({tag, "_pc"}, pc, cur_pc);
    chk({tag, "_pc_plus4"}, pc_plus4, cur_pc + 32'd4);
    step();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Each row: waits, rdata, fetch address, stalls, br, off, jmp, idx.
    // A row's fetch address is the previous row's expected next PC.
    vt[0]  = '{0, 32'h2008_0005, 32'h0000_0000, 0, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[1]  = '{0, 32'h0000_0020, 32'h0000_0004, 0, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[2]  = '{3, 32'h8C01_0000, 32'h0000_0008, 0, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[3]  = '{1, 32'h1000_0003, 32'h0000_000C, 1, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[4]  = '{0, 32'h1000_FFFE, 32'h0000_0010, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0};
    vt[5]  = '{2, 32'h1000_0000, 32'h0000_000C, 0, 1'b1, 32'h0400_0004, 1'b0, 26'h0};
    vt[6]  = '{0, 32'h0800_0040, 32'h1000_0020, 0, 1'b1, 32'h0000_0005, 1'b1, 26'h40};
    vt[7]  = '{0, 32'h0000_0000, 32'h1000_0100, 2, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[8]  = '{1, 32'h1000_0003, 32'h1000_0104, 0, 1'b1, 32'h3BFF_FFBD, 1'b0, 26'h0};
    vt[9]  = '{0, 32'h2108_0001, 32'hFFFF_FFFC, 0, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[10] = '{0, 32'h0C00_0003, 32'h0000_0000, 0, 1'b0, 32'h0,         1'b1, 26'h3FF_FFFF};
    vt[11] = '{0, 32'h0000_0020, 32'h0FFF_FFFC, 0, 1'b0, 32'h0,         1'b0, 26'h0};
    vt[12] = '{0, 32'h0800_0010, 32'h1000_0000, 0, 1'b0, 32'h0,         1'b1, 26'h10};

    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req_before_edge", 32'(imem_req), 32'd0);
    step();

    for (int i = 0; i < 13; i++) begin
      do_fetch($sformatf("v%0d_f", i), vt[i].waits, vt[i].rdata, vt[i].addr);
      do_exec($sformatf("v%0d_x", i), vt[i].stalls, vt[i].addr, vt[i].br, vt[i].off,
              vt[i].jmp, vt[i].idx);
    end

    // Stall in EXEC, then an asynchronous reset in the middle of a fetch wait
    do_fetch("h1_f", 0, 32'h8C22_0004, 32'h1000_0040);
    do_exec("h1_x", 2, 32'h1000_0040, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("h1_next_addr", imem_addr, 32'h1000_0044);
    step();
    step();
    chk("h1_wait_addr", imem_addr, 32'h1000_0044);
    chk("h1_wait_valid", 32'(instr_valid), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("h1_rst_pc", pc, 32'h0);
    chk("h1_rst_instr", instr, 32'h0);
    chk("h1_rst_valid", 32'(instr_valid), 32'd0);
    chk("h1_rst_req", 32'(imem_req), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step();

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: a NOP is issued after 16 wait cycles
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("to_req_c%0d", c), 32'(imem_req), 32'd1);
      chk($sformatf("to_valid_c%0d", c), 32'(instr_valid), 32'd0);
      chk($sformatf("to_err_c%0d", c), 32'(fetch_err), 32'd0);
      imem_ready = 1'b0;
      step();
    end
    exp_q.push_back(32'h0);
    chk("to_valid", 32'(instr_valid), 32'd1);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_instr", instr, exp_q.pop_front());
    do_exec("to_x", 0, 32'h0, 1'b0, 32'h0, 1'b0, 26'h0);
    chk("to_err_fetch", 32'(fetch_err), 32'd1);
    do_fetch("to_f2", 0, 32'h2008_0005, 32'h0000_0004);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("to_err_cleared", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
`else
    // Without the timeout feature, a long wait must simply keep requesting
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("nt_valid_c%0d", c), 32'(instr_valid), 32'd0);
      chk($sformatf("nt_err_c%0d", c), 32'(fetch_err), 32'd0);
      imem_ready = 1'b0;
      step();
    end
    do_fetch("nt_f", 0, 32'h2008_0005, 32'h0000_0000);
    chk("nt_err_end", 32'(fetch_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
